// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, microcycle and address-select encodings for the TB4004 core
package cpu_pkg;
  typedef enum logic [1:0] {ALIGN, FETCH1, FETCH2, HOLD} state_t;
  localparam logic [2:0] T_A1 = 3'd0;
  localparam logic [2:0] T_A2 = 3'd1;
  localparam logic [2:0] T_A3 = 3'd2;
  localparam logic [2:0] T_M1 = 3'd3;
  localparam logic [2:0] T_M2 = 3'd4;
  localparam logic [2:0] T_X1 = 3'd5;
  localparam logic [2:0] T_X2 = 3'd6;
  localparam logic [2:0] T_X3 = 3'd7;
  localparam logic [1:0] ASEL_LO   = 2'd0;
  localparam logic [1:0] ASEL_MID  = 2'd1;
  localparam logic [1:0] ASEL_HI   = 2'd2;
  localparam logic [1:0] ASEL_NONE = 2'd3;
endpackage

// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: instruction-cycle FSM and per-microcycle strobe decode
module cpu_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter bit TWO_WORD_EN = 1'b1,
  parameter bit HOLD_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cycle,
  input  logic       two_word,
  input  logic       io_op,
  input  logic       io_write,
  input  logic       hold,
  output logic       sync,
  output logic [1:0] addr_sel,
  output logic       opr_le,
  output logic       opa_le,
  output logic       pc_inc,
  output logic       cm_rom,
  output logic       bus_drive,
  output logic       word2,
  output logic       exec_en,
  output logic       held
);
  state_t r_state;
  logic   r_first;
  logic   w_tw;
  logic   w_hold;
  logic   w_f1;
  logic   w_act;
  logic   w_on;
  assign w_tw   = TWO_WORD_EN && two_word;
  assign w_hold = HOLD_EN && hold;
  assign w_f1   = r_state == FETCH1;
  // a fetch state only counts once the microcycle is known to be aligned
  assign w_act  = (w_f1 || r_state == FETCH2) && !(r_first && cycle != T_A1);
  assign w_on   = w_act && !rst;
  // state advances only at instruction boundaries; first edge after reset checks alignment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH1;
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (r_first && cycle != T_A1) r_state <= ALIGN;
      else if (cycle == T_X3)
        case (r_state)
          ALIGN:   r_state <= FETCH1;
          FETCH1:  r_state <= w_tw ? FETCH2 : (w_hold ? HOLD : FETCH1);
          FETCH2:  r_state <= w_hold ? HOLD : FETCH1;
          default: r_state <= w_hold ? HOLD : FETCH1;
        endcase
    end
  end
  // zero-latency strobe decode from registered state and the live cycle count
  always_comb begin
    addr_sel  = !w_act ? ASEL_NONE : cycle == T_A1 ? ASEL_LO : cycle == T_A2 ? ASEL_MID :
                cycle == T_A3 ? ASEL_HI : ASEL_NONE;
    sync      = w_on && cycle == T_X3;
    opr_le    = w_on && cycle == T_M1;
    opa_le    = w_on && cycle == T_M2;
    pc_inc    = w_on && cycle == T_X1;
    cm_rom    = w_on && (cycle == T_A3 || (w_f1 && io_op && cycle == T_X2));
    bus_drive = w_on && (cycle <= T_A3 || (w_f1 && io_write && cycle == T_X2));
    exec_en   = w_on && cycle == T_X3 && !(w_f1 && w_tw);
    word2     = !rst && r_state == FETCH2;
    held      = !rst && r_state == HOLD;
  end
endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// tb_cpu_cycle_sequencer: directed microcycle-by-microcycle checks of the instruction sequencer
module tb_cpu_cycle_sequencer;
  localparam int F1S = 0, F1T = 1, F1IO = 2, F2 = 3, HLD = 4, ALN = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] cycle = 3'd0;
  logic two_word = 1'b0, io_op = 1'b0, io_write = 1'b0, hold = 1'b0;
  logic sync, opr_le, opa_le, pc_inc, cm_rom, bus_drive, word2, exec_en, held;
  logic [1:0] addr_sel;
  logic [10:0] obs;
  int vec = 0;
  int miss = 0;

  cpu_cycle_sequencer dut (
    .clk(clk), .rst(rst), .cycle(cycle), .two_word(two_word), .io_op(io_op),
    .io_write(io_write), .hold(hold), .sync(sync), .addr_sel(addr_sel),
    .opr_le(opr_le), .opa_le(opa_le), .pc_inc(pc_inc), .cm_rom(cm_rom),
    .bus_drive(bus_drive), .word2(word2), .exec_en(exec_en), .held(held)
  );

  always #5 clk = ~clk;

  assign obs = {sync, addr_sel, opr_le, opa_le, pc_inc, cm_rom, bus_drive, word2, exec_en, held};

  // expected {sync, addr_sel, opr, opa, pc_inc, cm_rom, bus_drive, word2, exec_en, held}
  function automatic logic [10:0] exp_v(input int m, input int c);
    logic f;
    logic [1:0] a;
    f = m <= F2;
    a = (f && c < 3) ? 2'(c) : 2'd3;
    return {f && c == 7, a, f && c == 3, f && c == 4, f && c == 5,
            f && (c == 2 || (m == F1IO && c == 6)), f && (c < 3 || (m == F1IO && c == 6)),
            m == F2, f && c == 7 && m != F1T, m == HLD};
  endfunction

  task automatic chk(input string tag, input int c, input logic [10:0] e);
    vec++;
    assert (obs === e) else begin
      miss++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, obs, e);
    end
  endtask

  // drive cycles c0..c1 of one microcycle, hold high for c in [h_on, h_off)
  task automatic micro(input string tag, input int m, input logic tw, input logic iop,
                       input int h_on, input int h_off, input int c0, input int c1);
    two_word = tw;
    io_op = iop;
    io_write = iop;
    for (int c = c0; c <= c1; c++) begin
      cycle = 3'(c);
      hold = c >= h_on && c < h_off;
      #2 chk(tag, c, exp_v(m, c));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset", 0, 11'd0);
    rst = 1'b0;
    micro("single_a", F1S, 1'b0, 1'b0, 9, 9, 0, 7);
    micro("single_b", F1S, 1'b0, 1'b0, 9, 9, 0, 7);
    micro("two_w1", F1T, 1'b1, 1'b0, 9, 9, 0, 7);
    micro("two_w2", F2, 1'b1, 1'b1, 9, 9, 0, 7);
    micro("after_two", F1S, 1'b0, 1'b0, 9, 9, 0, 7);
    micro("io_single", F1IO, 1'b0, 1'b1, 9, 9, 0, 7);
    micro("hold_pulse", F1S, 1'b0, 1'b0, 2, 6, 0, 7);
    micro("hold_req", F1S, 1'b0, 1'b0, 3, 8, 0, 7);
    micro("hold_1", HLD, 1'b0, 1'b0, 0, 8, 0, 7);
    micro("hold_2", HLD, 1'b0, 1'b0, 0, 4, 0, 7);
    micro("resume", F1S, 1'b0, 1'b0, 9, 9, 0, 7);
    micro("tw_hold1", F1T, 1'b1, 1'b0, 2, 8, 0, 7);
    micro("tw_hold2", F2, 1'b0, 1'b0, 0, 8, 0, 7);
    micro("tw_held", HLD, 1'b0, 1'b0, 0, 4, 0, 7);
    micro("pre_rst1", F1T, 1'b1, 1'b0, 9, 9, 0, 7);
    micro("pre_rst2", F2, 1'b0, 1'b0, 9, 9, 0, 5);
    rst = 1'b1;
    #1 chk("async_rst", 5, exp_v(ALN, 5));
    cycle = 3'd3;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("release_c3", 3, exp_v(ALN, 3));
    @(posedge clk);
    #1;
    micro("align", ALN, 1'b0, 1'b0, 9, 9, 4, 7);
    micro("realigned", F1S, 1'b0, 1'b0, 9, 9, 0, 7);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
